led_serial_rx: RTL and testbench

- Receive end of the board's serial LED link: the peripheral side of the led_clk / led_sout / LED_PEN / led_clrn shifter interface.
- Oversamples the four link wires in the system clock domain, deserialises WIDTH bits, and on the latch strobe presents them as a parallel word.
- Used as an on-chip loopback/checker for the LED shifter and as a behavioural stand-in for the external shift-register/latch chain.

---
 rtl/led_serial_rx_pkg.sv | 12 +
 rtl/led_serial_rx_sync_edge.sv | 29 ++
 rtl/led_serial_rx.sv | 95 +++++++++
 tb/tb_led_serial_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/led_serial_rx_pkg.sv
// led_serial_rx_pkg: shared FSM encoding, default frame width and bit-count sizing
package led_serial_rx_pkg;

    typedef enum logic [1:0] {IDLE, RECV, LATCH} state_t;

    localparam int LED_WIDTH = 16;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/led_serial_rx_sync_edge.sv
// led_serial_rx_sync_edge: multi-flop synchroniser with history flop for rising-edge detect
module led_serial_rx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] s;
    logic                   h;

    // synchroniser chain followed by one history flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
            h <= 1'b0;
        end else begin
            s <= {s[SYNC_STAGES-2:0], d};
            h <= s[SYNC_STAGES-1];
        end
    end

    assign q    = s[SYNC_STAGES-1];
    assign rise = q & ~h;

endmodule

// File: rtl/led_serial_rx.sv
// led_serial_rx: oversampling receiver for the serial LED shift/latch link
module led_serial_rx
    import led_serial_rx_pkg::*;
#(
    parameter int WIDTH       = LED_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          EN,
    input  logic                          led_clk,
    input  logic                          led_sout,
    input  logic                          LED_PEN,
    input  logic                          led_clrn,
    output logic [WIDTH-1:0]              par_out,
    output logic                          frame_valid,
    output logic                          frame_err,
    output logic [cnt_width(WIDTH)-1:0]   bit_cnt
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, next;
    logic [WIDTH-1:0] shift;
    logic             clk_rise, pen_s, pen_rise, sout_s, clrn_s;
    logic             clk_lvl_unused, sout_rise_unused, clrn_rise_unused;
    logic             clk_ev, pen_ev, shift_en, latch_ok, frame_ok, frame_bad;

    led_serial_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk (
        .clk(clk), .rst(rst), .d(led_clk), .q(clk_lvl_unused), .rise(clk_rise)
    );
    led_serial_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sout (
        .clk(clk), .rst(rst), .d(led_sout), .q(sout_s), .rise(sout_rise_unused)
    );
    led_serial_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pen (
        .clk(clk), .rst(rst), .d(LED_PEN), .q(pen_s), .rise(pen_rise)
    );
    led_serial_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clrn (
        .clk(clk), .rst(rst), .d(led_clrn), .q(clrn_s), .rise(clrn_rise_unused)
    );

    // a led_clk rise is dropped while the latch strobe is high, which also covers a coincident strobe rise
    assign clk_ev = EN & clk_rise & ~pen_s;
    assign pen_ev = EN & pen_rise;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    // next state: clear beats strobe beats shift clock
    always_comb begin
        next = !clrn_s ? IDLE :
               state == LATCH ? IDLE :
               pen_ev ? LATCH :
               (state == IDLE && clk_ev) ? RECV : state;
    end

    // datapath controls decoded from state and conditioned edges
    always_comb begin
        latch_ok  = state == LATCH && clrn_s;
        frame_ok  = latch_ok && bit_cnt == CW'(WIDTH);
        frame_bad = latch_ok && bit_cnt != CW'(WIDTH);
        shift_en  = clrn_s && clk_ev && state != LATCH;
    end

    // shift register, bit counter, parallel word and frame pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift       <= '0;
            bit_cnt     <= '0;
            par_out     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= frame_ok;
            frame_err   <= frame_bad;
            if (frame_ok)
                par_out <= shift;
            if (!clrn_s) begin
                shift   <= '0;
                bit_cnt <= '0;
            end else if (state == LATCH) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shift   <= {shift[WIDTH-2:0], sout_s};
                bit_cnt <= bit_cnt == CW'(WIDTH + 1) ? bit_cnt : bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_serial_rx.sv
// tb_led_serial_rx: table-driven frames plus corner sequences, scoreboard on frame pulses
module tb_led_serial_rx;

    logic        clk = 1'b0, rst = 1'b1, EN = 1'b1;
    logic        led_clk = 1'b0, led_sout = 1'b0, LED_PEN = 1'b0, led_clrn = 1'b1;
    logic [15:0] par_out;
    logic        frame_valid, frame_err;
    logic [4:0]  bit_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {logic ok; logic [15:0] par;} exp_t;
    typedef struct {logic [15:0] data; int nbits;} vec_t;

    exp_t        exp_q[$];
    logic [15:0] model_par = '0;

    led_serial_rx dut (
        .clk(clk), .rst(rst), .EN(EN), .led_clk(led_clk), .led_sout(led_sout),
        .LED_PEN(LED_PEN), .led_clrn(led_clrn), .par_out(par_out),
        .frame_valid(frame_valid), .frame_err(frame_err), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one bit per 8 clk cycles, MSB first; bits above 15 (over-length frames) are sent as 1
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            led_sout = i < 16 ? w[i] : 1'b1;
            led_clk  = 1'b0;
            tick(4);
            led_clk  = 1'b1;
            tick(4);
        end
    endtask

    task automatic expect_frame(input logic ok, input logic [15:0] w);
        if (ok) model_par = w;
        exp_q.push_back({ok, model_par});
    endtask

    task automatic pulse_pen;
        LED_PEN = 1'b1;
        tick(4);
        LED_PEN = 1'b0;
        tick(4);
    endtask

    task automatic drain;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        if (exp_q.size() != 0) begin
            chk("pulse_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick(4);
    endtask

    // scoreboard: every frame pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && (frame_valid || frame_err)) begin
            exp_t e;
            chk("pulse_exclusive", {31'd0, frame_valid & frame_err}, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {frame_valid, frame_err}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("frame_kind", {frame_valid, frame_err}, {e.ok, ~e.ok});
                chk("par_out", par_out, e.par);
            end
        end
    end

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'hA5C3, 16};
        vecs[1] = '{16'h1234, 15};
        vecs[2] = '{16'h0F0F, 17};
        vecs[3] = '{16'h5A5A, 16};
        vecs[4] = '{16'h0000, 0};
        vecs[5] = '{16'h8001, 16};

        tick(3);
        rst = 1'b0;
        tick(6);
        chk("reset_par_out", par_out, 0);
        chk("reset_bit_cnt", bit_cnt, 0);
        chk("reset_pulses", {frame_valid, frame_err}, 0);

        foreach (vecs[k]) begin
            send_bits(vecs[k].data, vecs[k].nbits);
            chk($sformatf("bit_cnt_pre_%0d", k), bit_cnt, vecs[k].nbits > 17 ? 17 : vecs[k].nbits);
            expect_frame(vecs[k].nbits == 16, vecs[k].data);
            pulse_pen();
            drain();
            chk($sformatf("bit_cnt_post_%0d", k), bit_cnt, 0);
            chk($sformatf("par_hold_%0d", k), par_out, model_par);
        end

        send_bits(16'h7F7F, 7);
        chk("bit_cnt_before_clear", bit_cnt, 7);
        led_clrn = 1'b0;
        tick(4);
        chk("bit_cnt_cleared", bit_cnt, 0);
        chk("par_kept_on_clear", par_out, model_par);
        led_clrn = 1'b1;
        tick(4);
        send_bits(16'h0001, 16);
        expect_frame(1'b1, 16'h0001);
        pulse_pen();
        drain();

        send_bits(16'hC3A5, 16);
        led_clk = 1'b0;
        led_sout = 1'b1;
        tick(4);
        expect_frame(1'b1, 16'hC3A5);
        led_clk = 1'b1;
        LED_PEN = 1'b1;
        tick(4);
        LED_PEN = 1'b0;
        tick(4);
        drain();

        send_bits(16'h3C3C, 15);
        led_clk = 1'b0;
        tick(4);
        expect_frame(1'b0, 16'h0);
        led_clk = 1'b1;
        LED_PEN = 1'b1;
        tick(4);
        LED_PEN = 1'b0;
        tick(4);
        drain();

        EN = 1'b0;
        send_bits(16'hFFFF, 16);
        pulse_pen();
        tick(10);
        chk("en_off_bit_cnt", bit_cnt, 0);
        chk("en_off_par", par_out, model_par);
        EN = 1'b1;
        tick(8);
        chk("en_on_no_stale_shift", bit_cnt, 0);
        send_bits(16'h6996, 16);
        expect_frame(1'b1, 16'h6996);
        pulse_pen();
        drain();

        send_bits(16'h1234, 10);
        chk("bit_cnt_before_rst", bit_cnt, 10);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_par", par_out, 0);
        chk("async_rst_cnt", bit_cnt, 0);
        chk("async_rst_pulses", {frame_valid, frame_err}, 0);
        model_par = '0;
        led_clk = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(6);
        send_bits(16'hFFFF, 16);
        expect_frame(1'b1, 16'hFFFF);
        pulse_pen();
        drain();
        chk("final_par", par_out, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
